// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths and ALU op encodings for the ID/EX stage.
// The ALU op is the low three bits of the 6-bit opcode.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OPC_W  = 6;
  localparam int IMM_W  = 16;

  localparam int ALU_OP_MSB = 2;
  localparam int ALU_OP_LSB = 0;

  typedef enum logic [2:0] {
    ALU_MOV  = 3'b000,
    ALU_NOT  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [OPC_W-1:0] opc);
    return alu_op_e'(opc[ALU_OP_MSB:ALU_OP_LSB]);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-slot inputs and EX-slot outputs of the ID/EX stage.
//   master : decode side (drives id_*, observes ex_* and hazard_stall)
//   slave  : the stage itself
interface id_ex_stage_if #(parameter int DATA_W = id_ex_stage_pkg::DATA_W);
  import id_ex_stage_pkg::*;

  logic              id_valid;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [IMM_W-1:0]  id_imm;
  logic              id_use_imm;
  logic              id_wb_en;
  logic              id_is_load;

  logic              hazard_stall;

  logic              ex_valid;
  logic              ex_wb_en;
  logic              ex_is_load;
  logic [OPC_W-1:0]  ex_opcode;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_r2;
  logic [DATA_W-1:0] ex_r3;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_wb_en, id_is_load,
    input  hazard_stall, ex_valid, ex_wb_en, ex_is_load, ex_opcode, ex_rd,
           ex_r2, ex_r3
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_wb_en, id_is_load,
    output hazard_stall, ex_valid, ex_wb_en, ex_is_load, ex_opcode, ex_rd,
           ex_r2, ex_r3
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: selects one source operand.
//   rnum/rf_data        : register number and register-file read data
//   ex_fwd_en/ex_rd/alu_out : EX-slot forward source (already qualified)
//   mem_wb_en/mem_rd/mem_data : MEM-slot forward source
//   operand             : EX result > MEM result > register file
// Register 0 is hard-wired, so it never takes a forwarded value.
module id_ex_stage_fwd_mux #(parameter int DATA_W = id_ex_stage_pkg::DATA_W) (
  input  logic [id_ex_stage_pkg::REG_W-1:0] rnum,
  input  logic [DATA_W-1:0]                 rf_data,
  input  logic                              ex_fwd_en,
  input  logic [id_ex_stage_pkg::REG_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]                 alu_out,
  input  logic                              mem_wb_en,
  input  logic [id_ex_stage_pkg::REG_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]                 mem_data,
  output logic [DATA_W-1:0]                 operand
);

  logic nonzero;

  always_comb begin
    nonzero = (rnum != '0);
    operand = rf_data;
    if (nonzero && ex_fwd_en && (ex_rd == rnum)) begin
      operand = alu_out;
    end else if (nonzero && mem_wb_en && (mem_rd == rnum)) begin
      operand = mem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//   clk, rst_n           : clock, async active-low reset
//   bus (slave)          : decode-slot inputs, EX-slot outputs, hazard_stall
//   alu_out              : EX-slot ALU result (forward source)
//   mem_wb_en/rd/data    : MEM-slot result (forward source)
//   stall, flush         : downstream hold / kill EX contents
//   bubble_cnt           : saturating count of load-use bubbles
module id_ex_stage #(parameter int DATA_W = id_ex_stage_pkg::DATA_W) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_stage_if.slave        bus,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                mem_wb_en,
  input  logic [4:0]          mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                stall,
  input  logic                flush,
  output logic [15:0]         bubble_cnt
);
  import id_ex_stage_pkg::*;

  logic              ex_valid_q;
  logic              ex_wb_en_q;
  logic              ex_is_load_q;
  logic [OPC_W-1:0]  ex_opcode_q;
  logic [REG_W-1:0]  ex_rd_q;
  logic [DATA_W-1:0] ex_r2_q;
  logic [DATA_W-1:0] ex_r3_q;
  logic [15:0]       bubble_cnt_q;

  logic              ex_fwd_en;
  logic              hazard;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b_fwd;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] imm_sext;

  // A load's data is not ready in EX, so it is never an EX forward source;
  // the hazard logic holds the consumer until the load reaches MEM.
  always_comb ex_fwd_en = ex_valid_q & ex_wb_en_q & ~ex_is_load_q;

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .rnum      (bus.id_rs),
    .rf_data   (bus.id_rs_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd_q),
    .alu_out   (alu_out),
    .mem_wb_en (mem_wb_en),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .operand   (op_a)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .rnum      (bus.id_rt),
    .rf_data   (bus.id_rt_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd_q),
    .alu_out   (alu_out),
    .mem_wb_en (mem_wb_en),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .operand   (op_b_fwd)
  );

  always_comb begin
    imm_sext = {{(DATA_W-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm};
    op_b     = bus.id_use_imm ? imm_sext : op_b_fwd;
    // rt only matters as a hazard source when it is actually read.
    hazard   = bus.id_valid & ex_valid_q & ex_is_load_q & (ex_rd_q != '0) &
               ((ex_rd_q == bus.id_rs) |
                ((ex_rd_q == bus.id_rt) & ~bus.id_use_imm));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_wb_en_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_opcode_q  <= OPC_W'(ALU_MOV);
      ex_rd_q      <= '0;
      ex_r2_q      <= '0;
      ex_r3_q      <= '0;
      bubble_cnt_q <= '0;
    end else if (flush) begin
      ex_valid_q   <= 1'b0;
      ex_wb_en_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else if (!stall) begin
      if (hazard) begin
        ex_valid_q   <= 1'b0;
        ex_wb_en_q   <= 1'b0;
        ex_is_load_q <= 1'b0;
        if (bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end else begin
        ex_valid_q   <= bus.id_valid;
        ex_wb_en_q   <= bus.id_wb_en & bus.id_valid;
        ex_is_load_q <= bus.id_is_load & bus.id_valid;
        ex_opcode_q  <= bus.id_opcode;
        ex_rd_q      <= bus.id_rd;
        ex_r2_q      <= op_a;
        ex_r3_q      <= op_b;
      end
    end
  end

  always_comb begin
    bus.hazard_stall = hazard;
    bus.ex_valid     = ex_valid_q;
    bus.ex_wb_en     = ex_wb_en_q;
    bus.ex_is_load   = ex_is_load_q;
    bus.ex_opcode    = ex_opcode_q;
    bus.ex_rd        = ex_rd_q;
    bus.ex_r2        = ex_r2_q;
    bus.ex_r3        = ex_r3_q;
    bubble_cnt       = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for the ID/EX stage with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are
// sampled 1 ns after the edge that should have captured them.
module tb_id_ex_stage;

  localparam logic [5:0] OP_MOV = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h03;
  localparam logic [5:0] OP_SUB = 6'h06;
  localparam logic [5:0] OP_LD  = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] alu_out = '0;
  logic        mem_wb_en = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage_if #(.DATA_W(32)) bus ();

  id_ex_stage #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_out    (alu_out),
    .mem_wb_en  (mem_wb_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .stall      (stall),
    .flush      (flush),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] opc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic use_imm, input logic [15:0] imm,
                       input logic wb, input logic ld);
    bus.id_valid   = v;
    bus.id_opcode  = opc;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_rs_data = rsd;
    bus.id_rt_data = rtd;
    bus.id_use_imm = use_imm;
    bus.id_imm     = imm;
    bus.id_wb_en   = wb;
    bus.id_is_load = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, "_wb"},    32'(bus.ex_wb_en), 32'd0);
    chk({tag, "_ld"},    32'(bus.ex_is_load), 32'd0);
    chk({tag, "_opc"},   32'(bus.ex_opcode), 32'd0);
    chk({tag, "_rd"},    32'(bus.ex_rd), 32'd0);
    chk({tag, "_r2"},    bus.ex_r2, 32'd0);
    chk({tag, "_r3"},    bus.ex_r3, 32'd0);
    chk({tag, "_bub"},   32'(bubble_cnt), 32'd0);
    chk({tag, "_haz"},   32'(bus.hazard_stall), 32'd0);
  endtask

  initial begin
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 16'h0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");

    // Add r3 <= r1 + r2 (r1=5, r2=7)
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("no_comb_path", 32'(bus.ex_valid), 32'd0);
    step();
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_wb",    32'(bus.ex_wb_en), 32'd1);
    chk("add_ld",    32'(bus.ex_is_load), 32'd0);
    chk("add_opc",   32'(bus.ex_opcode), 32'h03);
    chk("add_rd",    32'(bus.ex_rd), 32'd3);
    chk("add_r2",    bus.ex_r2, 32'd5);
    chk("add_r3",    bus.ex_r3, 32'd7);

    // Sub r4 <= r3 - r1: r3 forwarded from EX (alu_out = 12)
    alu_out = 32'd12;
    drive(1'b1, OP_SUB, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("sub_r2_fwd_ex", bus.ex_r2, 32'd12);
    chk("sub_r3",        bus.ex_r3, 32'd5);
    chk("sub_opc",       32'(bus.ex_opcode), 32'h06);

    // Load r5; no hazard against a non-load in EX
    alu_out = 32'd7;
    drive(1'b1, OP_LD, 5'd0, 5'd0, 5'd5, 32'h100, 32'd0, 1'b1, 16'd4, 1'b1, 1'b1);
    #1 chk("ld_no_haz", 32'(bus.hazard_stall), 32'd0);
    step();
    chk("ld_is_load", 32'(bus.ex_is_load), 32'd1);
    chk("ld_r2",      bus.ex_r2, 32'h100);
    chk("ld_r3",      bus.ex_r3, 32'd4);

    // Add r7 <= r5 + r2 with load r5 in EX: one bubble
    alu_out = 32'h104;
    drive(1'b1, OP_ADD, 5'd5, 5'd2, 5'd7, 32'hDEAD, 32'd7, 1'b0, 16'h0, 1'b1, 1'b0);
    #1 chk("luse_haz", 32'(bus.hazard_stall), 32'd1);
    step();
    chk("bub_valid", 32'(bus.ex_valid), 32'd0);
    chk("bub_wb",    32'(bus.ex_wb_en), 32'd0);
    chk("bub_ld",    32'(bus.ex_is_load), 32'd0);
    chk("bub_cnt1",  32'(bubble_cnt), 32'd1);
    chk("bub_haz_clr", 32'(bus.hazard_stall), 32'd0);
    mem_wb_en = 1'b1; mem_rd = 5'd5; mem_data = 32'h77;
    step();
    chk("luse_valid",  32'(bus.ex_valid), 32'd1);
    chk("luse_r2_mem", bus.ex_r2, 32'h77);
    chk("luse_r3",     bus.ex_r3, 32'd7);
    chk("luse_cnt",    32'(bubble_cnt), 32'd1);

    // EX and MEM both write r6: EX wins
    mem_wb_en = 1'b0;
    drive(1'b1, OP_MOV, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    alu_out = 32'hAAAA; mem_wb_en = 1'b1; mem_rd = 5'd6; mem_data = 32'h5555;
    drive(1'b1, OP_ADD, 5'd6, 5'd6, 5'd8, 32'h1111, 32'h2222, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("prio_r2_ex", bus.ex_r2, 32'hAAAA);
    chk("prio_r3_ex", bus.ex_r3, 32'hAAAA);
    // MEM only (EX now writes r8)
    alu_out = 32'hBBBB;
    drive(1'b1, OP_ADD, 5'd6, 5'd9, 5'd10, 32'h1111, 32'h9999, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("mem_r2", bus.ex_r2, 32'h5555);
    chk("rf_r3",  bus.ex_r3, 32'h9999);

    // r0 never forwarded
    mem_wb_en = 1'b0;
    drive(1'b1, OP_MOV, 5'd1, 5'd0, 5'd0, 32'h42, 32'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    alu_out = 32'hBEEF; mem_wb_en = 1'b1; mem_rd = 5'd0; mem_data = 32'hCAFE;
    drive(1'b1, OP_ADD, 5'd0, 5'd0, 5'd11, 32'h1234, 32'h4321, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("r0_r2", bus.ex_r2, 32'h1234);
    chk("r0_r3", bus.ex_r3, 32'h4321);

    // Immediate overrides forwarding (EX and MEM both write r11)
    alu_out = 32'h3333; mem_wb_en = 1'b1; mem_rd = 5'd11; mem_data = 32'h4444;
    drive(1'b1, OP_ADD, 5'd1, 5'd11, 5'd12, 32'd1, 32'h5, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    step();
    chk("imm_neg_r3", bus.ex_r3, 32'hFFFFFFFE);
    chk("imm_r2",     bus.ex_r2, 32'd1);
    drive(1'b1, OP_ADD, 5'd1, 5'd12, 5'd13, 32'd1, 32'h5, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    step();
    chk("imm_pos_r3", bus.ex_r3, 32'h00007FFF);

    // Load in EX, rt matches but immediate in use: no hazard
    mem_wb_en = 1'b0;
    drive(1'b1, OP_LD, 5'd0, 5'd0, 5'd13, 32'h200, 32'd0, 1'b1, 16'h0, 1'b1, 1'b1);
    step();
    drive(1'b1, OP_ADD, 5'd1, 5'd13, 5'd14, 32'd3, 32'd0, 1'b1, 16'd5, 1'b1, 1'b0);
    #1 chk("imm_rt_no_haz", 32'(bus.hazard_stall), 32'd0);
    bus.id_use_imm = 1'b0;
    #1 chk("rt_haz", 32'(bus.hazard_stall), 32'd1);
    bus.id_valid = 1'b0;
    #1 chk("invalid_no_haz", 32'(bus.hazard_stall), 32'd0);
    bus.id_valid = 1'b1;
    bus.id_use_imm = 1'b1;
    step();
    chk("imm_ld_valid", 32'(bus.ex_valid), 32'd1);
    chk("imm_ld_r3",    bus.ex_r3, 32'd5);
    chk("imm_ld_cnt",   32'(bubble_cnt), 32'd1);

    // Invalid decode slot masks wb/load
    drive(1'b0, OP_LD, 5'd0, 5'd0, 5'd15, 32'd0, 32'd0, 1'b0, 16'h0, 1'b1, 1'b1);
    step();
    chk("inv_valid", 32'(bus.ex_valid), 32'd0);
    chk("inv_wb",    32'(bus.ex_wb_en), 32'd0);
    chk("inv_ld",    32'(bus.ex_is_load), 32'd0);

    // Stall + flush same edge: flush wins, operands held
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd16, 32'h10, 32'h20, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("pre_sf_valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b1, OP_SUB, 5'd1, 5'd2, 5'd17, 32'h30, 32'h40, 1'b0, 16'h0, 1'b1, 1'b0);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("sf_valid", 32'(bus.ex_valid), 32'd0);
    chk("sf_wb",    32'(bus.ex_wb_en), 32'd0);
    chk("sf_rd",    32'(bus.ex_rd), 32'd16);
    chk("sf_r2",    bus.ex_r2, 32'h10);
    chk("sf_opc",   32'(bus.ex_opcode), 32'h03);
    stall = 1'b0; flush = 1'b0;

    // Stall for 3 cycles with a load-use hazard pending: everything holds
    drive(1'b1, OP_LD, 5'd0, 5'd0, 5'd18, 32'h300, 32'd0, 1'b1, 16'd8, 1'b1, 1'b1);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 5'd18, 5'd2, 5'(19 + i), 32'h99 + 32'(i), 32'd2, 1'b0, 16'h0, 1'b1, 1'b0);
      #1 chk("stl_haz", 32'(bus.hazard_stall), 32'd1);
      step();
      chk("stl_valid", 32'(bus.ex_valid), 32'd1);
      chk("stl_ld",    32'(bus.ex_is_load), 32'd1);
      chk("stl_rd",    32'(bus.ex_rd), 32'd18);
      chk("stl_r2",    bus.ex_r2, 32'h300);
      chk("stl_r3",    bus.ex_r3, 32'd8);
      chk("stl_opc",   32'(bus.ex_opcode), 32'h20);
      chk("stl_cnt",   32'(bubble_cnt), 32'd1);
    end
    stall = 1'b0;
    step();
    chk("post_stl_valid", 32'(bus.ex_valid), 32'd0);
    chk("post_stl_cnt",   32'(bubble_cnt), 32'd2);

    // Reset pulsed between edges
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd20, 32'h5, 32'h6, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_rst_r2",    bus.ex_r2, 32'h5);
    chk("post_rst_cnt",   32'(bubble_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
